// File: rtl/masked_join_stream_bv_pkg.sv
// Package masked_pkg: helpers shared by the masked join block and its share lanes.
//   beat_e    - what the control path does with the current cycle's input beat
//   f_cnt_w   - width of the beat counter for a given beat count per word
//   f_slot_lo - low bit of accumulator slot k, honouring the slot ordering
package masked_pkg;

  typedef enum logic [1:0] {
    BEAT_IDLE,   // no beat taken this cycle
    BEAT_PART,   // non-final beat: goes into the accumulator
    BEAT_FINAL,  // final beat: full word goes to the output register
    BEAT_DROP    // partial word abandoned by in_clear
  } beat_e;

  function automatic int f_cnt_w(input int num_parts);
    return (num_parts > 1) ? $clog2(num_parts) : 1;
  endfunction

  function automatic int f_slot_lo(input int k, input bit msb_first,
                                   input int num_parts, input int part_width);
    return msb_first ? (num_parts - 1 - k) * part_width : k * part_width;
  endfunction

endpackage

// File: rtl/masked_join_stream_bv_if.sv
// Stream bundle of the masked join block.
//   in_valid/out_ready/in_a   : narrow input beats, one PART_WIDTH slice per share
//   out_valid/in_ready/out_b  : joined word, one NUM_PARTS*PART_WIDTH lane per share
//   in_clear                  : abort of the partial word being collected
//   out_busy                  : a partial word is pending
// master = environment side, slave = join block side.
interface masked_join_stream_bv_if #(
  parameter int NUM_SHARES = 2,
  parameter int PART_WIDTH = 15,
  parameter int NUM_PARTS  = 2
);
  logic                                            in_clear;
  logic                                            in_valid;
  logic                                            out_ready;
  logic [NUM_SHARES-1:0][PART_WIDTH-1:0]           in_a;
  logic                                            out_valid;
  logic                                            in_ready;
  logic [NUM_SHARES-1:0][NUM_PARTS*PART_WIDTH-1:0] out_b;
  logic                                            out_busy;

  modport master (
    output in_clear, in_valid, in_a, in_ready,
    input  out_ready, out_valid, out_b, out_busy
  );

  modport slave (
    input  in_clear, in_valid, in_a, in_ready,
    output out_ready, out_valid, out_b, out_busy
  );
endinterface

// File: rtl/masked_join_stream_bv_slot.sv
// masked_share_slot_reg: one share lane of the masked join.
// Holds the slot-addressed accumulator and the registered output word for a
// single share; nothing in here ever sees another share's data.
//   clk, rst_n : clock, async active-low reset
//   clear      : zero the accumulator
//   wr_part    : write beat into slot `slot` of the accumulator
//   wr_final   : load {beat in slot `slot`, accumulator} into word_p1
//   slot       : current beat index
//   beat       : this share's input slice
//   word_p1    : this share's joined output word
module masked_share_slot_reg
  import masked_pkg::*;
#(
  parameter int PART_WIDTH = 15,
  parameter int NUM_PARTS  = 2,
  parameter bit MSB_FIRST  = 1'b0,
  localparam int CNT_W  = f_cnt_w(NUM_PARTS),
  localparam int WORD_W = NUM_PARTS * PART_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  wr_part,
  input  logic                  wr_final,
  input  logic [CNT_W-1:0]      slot,
  input  logic [PART_WIDTH-1:0] beat,
  output logic [WORD_W-1:0]     word_p1
);

  logic [WORD_W-1:0] acc_p0;
  logic [WORD_W-1:0] acc_nxt;

  // Accumulator with the current beat dropped into its slot; this is also
  // the complete word when the beat is the final one.
  always_comb begin
    acc_nxt = acc_p0;
    for (int k = 0; k < NUM_PARTS; k++) begin
      if (slot == CNT_W'(k))
        acc_nxt[f_slot_lo(k, MSB_FIRST, NUM_PARTS, PART_WIDTH) +: PART_WIDTH] = beat;
    end
  end

  // p0 -> p1: accumulator and output word registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p0  <= '0;
      word_p1 <= '0;
    end else begin
      if (clear)
        acc_p0 <= '0;
      else if (wr_part)
        acc_p0 <= acc_nxt;
      if (wr_final)
        word_p1 <= acc_nxt;
    end
  end

endmodule

// File: rtl/masked_join_stream_bv.sv
// masked_join_stream_bv: joins NUM_PARTS narrow beats of a masked (shared)
// slice into one wide shared word, lane by lane, with no cross-share logic.
//   in_clock : clock, rising edge
//   in_reset : async reset, active-low
//   bus      : slave side of masked_join_stream_bv_if (input beats, joined
//              word, clear, busy)
// The beat counter and the output valid are share-independent and live here;
// each share's data path is a masked_share_slot_reg lane.
module masked_join_stream_bv
  import masked_pkg::*;
#(
  parameter int NUM_SHARES = 2,
  parameter int PART_WIDTH = 15,
  parameter int NUM_PARTS  = 2,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                    in_clock,
  input  logic                    in_reset,
  masked_join_stream_bv_if.slave  bus
);

  localparam int               CNT_W  = f_cnt_w(NUM_PARTS);
  localparam int               WORD_W = NUM_PARTS * PART_WIDTH;
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(NUM_PARTS - 1);

  logic [CNT_W-1:0]                 cnt_p0;
  logic                             vld_p1;
  logic                             last_slot;
  logic                             accept;
  logic                             consume;
  logic                             wr_part;
  logic                             wr_final;
  beat_e                            beat_kind;
  logic [NUM_SHARES-1:0][WORD_W-1:0] word_p1;

  // Only the final beat can stall, and only while a word is held unconsumed;
  // a consume in the same cycle frees the output register for the new word.
  assign last_slot     = (cnt_p0 == LAST);
  assign bus.out_ready = !(last_slot && vld_p1 && !bus.in_ready);
  assign accept        = bus.in_valid && bus.out_ready;
  assign consume       = vld_p1 && bus.in_ready;

  // Clear outranks an accepted beat: the beat is dropped.
  always_comb begin
    beat_kind = BEAT_IDLE;
    if (bus.in_clear)
      beat_kind = BEAT_DROP;
    else if (accept)
      beat_kind = last_slot ? BEAT_FINAL : BEAT_PART;
  end

  assign wr_part  = (beat_kind == BEAT_PART);
  assign wr_final = (beat_kind == BEAT_FINAL);

  // p0 -> p1: beat counter and output valid
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      cnt_p0 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      case (beat_kind)
        BEAT_DROP:  cnt_p0 <= '0;
        BEAT_PART:  cnt_p0 <= cnt_p0 + CNT_W'(1);
        BEAT_FINAL: cnt_p0 <= '0;
        default:    cnt_p0 <= cnt_p0;
      endcase
      if (wr_final)
        vld_p1 <= 1'b1;
      else if (consume)
        vld_p1 <= 1'b0;
    end
  end

  for (genvar s = 0; s < NUM_SHARES; s++) begin : g_share
    masked_share_slot_reg #(
      .PART_WIDTH (PART_WIDTH),
      .NUM_PARTS  (NUM_PARTS),
      .MSB_FIRST  (MSB_FIRST)
    ) u_lane (
      .clk      (in_clock),
      .rst_n    (in_reset),
      .clear    (bus.in_clear),
      .wr_part  (wr_part),
      .wr_final (wr_final),
      .slot     (cnt_p0),
      .beat     (bus.in_a[s]),
      .word_p1  (word_p1[s])
    );
  end

  assign bus.out_b     = word_p1;
  assign bus.out_valid = vld_p1;
  assign bus.out_busy  = (cnt_p0 != '0);

endmodule
